pll_reset_sequencer: RTL

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/ifclocks_pkg.sv | 24 ++
 rtl/pll_reset_sequencer_sync2.sv | 25 ++
 rtl/pll_reset_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ifclocks_pkg.sv
// Shared state encoding and default timing for the PLL reset sequencer.
package ifclocks_pkg;

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_SETTLE    = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_e;

   // Defaults assume a 24 MHz reference clock.
   localparam int DEF_RST_CYCLES    = 24;     // 1 us reset pulse
   localparam int DEF_LOCK_TIMEOUT  = 24000;  // 1 ms lock window
   localparam int DEF_SETTLE_CYCLES = 2400;   // 100 us of stable lock
   localparam int DEF_MAX_RETRIES   = 7;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // Both stages clear on reset so the synchronized level starts low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock sequencer: pulses the PLL reset, waits for a stable lock,
// then releases the downstream reset; retries on timeout and gives up after
// MAX_RETRIES until software requests another attempt.
//
//   state        | meaning
//   -------------+----------------------------------------------------------
//   ST_PLL_RST   | pll_rst asserted for RST_CYCLES cycles
//   ST_WAIT_LOCK | waiting up to LOCK_TIMEOUT cycles for locked_s
//   ST_SETTLE    | counting SETTLE_CYCLES consecutive locked cycles
//   ST_RUN       | PLL stable, sys_rst_n released, ready high
//   ST_FAIL      | retries exhausted, waiting for retry_req
module pll_reset_sequencer
   import ifclocks_pkg::*;
#(
   parameter int RST_CYCLES    = DEF_RST_CYCLES,
   parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       retry_req,
   output logic       pll_rst,
   output logic       sys_rst_n,
   output logic       ready,
   output logic       fail,
   output logic [3:0] retry_cnt,
   output logic [7:0] loss_cnt
);

   localparam int CNT_MAX = max3(LOCK_TIMEOUT, SETTLE_CYCLES, RST_CYCLES);
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   // The counter starts at 0 on entry, so terminal count is N-1.
   localparam logic [CNT_W-1:0] RST_TC    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] LOCK_TC   = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

   logic             locked_s;
   state_e           state_q,     state_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic [3:0]       retry_q,     retry_d;
   logic [7:0]       loss_q,      loss_d;
   logic             pll_rst_q,   pll_rst_d;
   logic             sys_rst_n_q, sys_rst_n_d;
   logic             ready_q,     ready_d;
   logic             fail_q,      fail_d;

   sync2 u_sync_locked (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (locked_s)
   );

   // Next state, counters, and outputs decoded from the next state so they
   // change on the same edge as the state register.
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      loss_d  = loss_q;

      case (state_q)
         ST_PLL_RST: begin
            if (cnt_q == RST_TC) state_d = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            // Lock takes priority over a coincident timeout.
            if (locked_s) begin
               state_d = ST_SETTLE;
            end else if (cnt_q == LOCK_TC) begin
               if (retry_q == RETRY_MAX) begin
                  state_d = ST_FAIL;
               end else begin
                  retry_d = retry_q + 4'd1;
                  state_d = ST_PLL_RST;
               end
            end
         end
         ST_SETTLE: begin
            if (!locked_s) begin
               state_d = ST_WAIT_LOCK;
            end else if (cnt_q == SETTLE_TC) begin
               state_d = ST_RUN;
               retry_d = 4'd0;
            end
         end
         ST_RUN: begin
            if (!locked_s) begin
               state_d = ST_PLL_RST;
               if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
            end
         end
         ST_FAIL: begin
            if (retry_req) begin
               retry_d = 4'd0;
               state_d = ST_PLL_RST;
            end
         end
         default: state_d = ST_PLL_RST;
      endcase

      // RUN and FAIL are untimed, so the counter parks at zero there.
      if ((state_d != state_q) || (state_q == ST_RUN) || (state_q == ST_FAIL))
         cnt_d = '0;
      else
         cnt_d = cnt_q + 1'b1;

      pll_rst_d   = (state_d == ST_PLL_RST);
      sys_rst_n_d = (state_d == ST_RUN);
      ready_d     = (state_d == ST_RUN);
      fail_d      = (state_d == ST_FAIL);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_PLL_RST;
         cnt_q       <= '0;
         retry_q     <= 4'd0;
         loss_q      <= 8'd0;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         loss_q      <= loss_d;
         pll_rst_q   <= pll_rst_d;
         sys_rst_n_q <= sys_rst_n_d;
         ready_q     <= ready_d;
         fail_q      <= fail_d;
      end
   end

   assign pll_rst   = pll_rst_q;
   assign sys_rst_n = sys_rst_n_q;
   assign ready     = ready_q;
   assign fail      = fail_q;
   assign retry_cnt = retry_q;
   assign loss_cnt  = loss_q;

endmodule
